// File: rtl/cam_pkg.sv
// Shared sizing, pixel format and capture state encoding for the camera / frame buffer path.
package cam_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned LINE_W = 9;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } cam_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// OV7670 input stage: registers the raw bus, detects VSYNC/HREF edges and packs byte pairs into RGB444.
// The line_end output exists only when CAM_CAPTURE_STATUS_EN is defined.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic             i_p_clk,
  input  logic             i_rstn,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic [7:0]       i_data,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pixel,
  output logic             frame_start,
  output logic             frame_end
`ifdef CAM_CAPTURE_STATUS_EN
  ,
  output logic             line_end
`endif
);

  logic       vs_q;
  logic       vs_d;
  logic       href_q;
  logic [7:0] data_q;
  logic [3:0] r_q;
  logic       phase_q;
  logic       rise_c;
  logic       fall_c;
  rgb444_t    pix_c;

  assign rise_c = vs_q & ~vs_d;
  assign fall_c = ~vs_q & vs_d;
  assign pix_c  = '{r: r_q, g: data_q[7:4], b: data_q[3:0]};

  // Any VSYNC edge or HREF gap restarts the pair, so a stray odd byte never shifts later pixels.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      vs_q        <= 1'b0;
      vs_d        <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      r_q         <= '0;
      phase_q     <= 1'b0;
      pix_valid   <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      vs_q        <= i_vsync;
      vs_d        <= vs_q;
      href_q      <= i_href;
      data_q      <= i_data;
      frame_start <= fall_c;
      frame_end   <= rise_c;
      pix_valid   <= href_q & phase_q & ~fall_c;
      pixel       <= pix_c;
      phase_q     <= href_q & ~phase_q & ~rise_c & ~fall_c;
      if (href_q && !phase_q) begin
        r_q <= data_q[3:0];
      end
    end
  end

`ifdef CAM_CAPTURE_STATUS_EN
  logic href_d;

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      href_d   <= 1'b0;
      line_end <= 1'b0;
    end else begin
      href_d   <= href_q;
      line_end <= ~href_q & href_d;
    end
  end
`endif

endmodule

// File: rtl/cam_capture.sv
// Camera write side of the RGB444 frame buffer: skips settling frames, then writes frame-aligned pixels.
// Optional status ports (o_frame_err, o_line_count) are built when CAM_CAPTURE_STATUS_EN is defined.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned START_FRAMES = 2,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480
) (
  input  logic              i_p_clk,
  input  logic              i_rstn,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [PIX_W-1:0]  o_wdata,
  output logic              o_wr,
  output logic              o_frame_done,
  output logic              o_armed
`ifdef CAM_CAPTURE_STATUS_EN
  ,
  output logic              o_frame_err,
  output logic [LINE_W-1:0] o_line_count
`endif
);

  localparam int unsigned FRAME_PIXELS = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam int unsigned CNT_W        = (START_FRAMES > 0) ? $clog2(START_FRAMES + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic             pix_valid;
  logic [PIX_W-1:0] pixel;
  logic             frame_start;
  logic             frame_end;
`ifdef CAM_CAPTURE_STATUS_EN
  logic             line_end;
`endif

  cam_state_e        state_q;
  cam_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              full_q;
  logic              full_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [PIX_W-1:0]  wdata_d;
  logic              wr_d;
  logic              done_d;

  cam_byte_pack u_pack (
    .i_p_clk     (i_p_clk),
    .i_rstn      (i_rstn),
    .i_vsync     (i_vsync),
    .i_href      (i_href),
    .i_data      (i_data),
    .pix_valid   (pix_valid),
    .pixel       (pixel),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef CAM_CAPTURE_STATUS_EN
    ,
    .line_end    (line_end)
`endif
  );

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_wr         <= 1'b0;
      o_frame_done <= 1'b0;
      o_armed      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      o_waddr      <= waddr_d;
      o_wdata      <= wdata_d;
      o_wr         <= wr_d;
      o_frame_done <= done_d;
      o_armed      <= (state_d == ACTIVE);
    end
  end

  // Address advances the cycle after a write and sticks at the last pixel once the frame is full.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    wdata_d = o_wdata;
    waddr_d = (o_wr && !full_q) ? o_waddr + ADDR_W'(1) : o_waddr;
    unique case (state_q)
      INIT: begin
        if (cnt_q >= CNT_W'(START_FRAMES)) begin
          state_d = WAIT_VS;
        end else if (frame_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_VS: begin
        if (frame_start) begin
          state_d = ACTIVE;
          waddr_d = '0;
          full_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          done_d  = 1'b1;
          waddr_d = '0;
          full_d  = 1'b0;
        end else if (pix_valid && !full_q) begin
          wr_d    = 1'b1;
          wdata_d = pixel;
          if (o_waddr == LAST_ADDR) begin
            full_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

`ifdef CAM_CAPTURE_STATUS_EN
  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W + 1)'(FRAME_PIXELS);

  logic [ADDR_W:0]   wr_cnt_q;
  logic              ovf_q;
  logic [LINE_W-1:0] lines_q;
  logic              ovf_c;
  logic [LINE_W-1:0] lines_c;

  assign ovf_c   = (state_q == ACTIVE) && !frame_end && pix_valid && full_q;
  assign lines_c = lines_q + LINE_W'(line_end);

  // Per-frame bookkeeping; the error flag is sticky until reset.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      wr_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      lines_q      <= '0;
      o_frame_err  <= 1'b0;
      o_line_count <= '0;
    end else begin
      lines_q <= frame_end ? '0 : lines_c;
      if (frame_end || frame_start) begin
        wr_cnt_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (wr_d) begin
          wr_cnt_q <= wr_cnt_q + (ADDR_W + 1)'(1);
        end
        if (ovf_c) begin
          ovf_q <= 1'b1;
        end
      end
      if (state_q == ACTIVE && frame_end) begin
        o_line_count <= lines_c;
        if (wr_cnt_q != FRAME_CNT || ovf_q) begin
          o_frame_err <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Randomized self-checking bench for cam_capture against a per-byte reference model with a write scoreboard.
`timescale 1ns/1ps
module tb_cam_capture;
  import cam_pkg::*;

  localparam int unsigned SF = 2;
  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned FP = H * V;

  logic              clk   = 1'b0;
  logic              rstn  = 1'b0;
  logic              vsync = 1'b0;
  logic              href  = 1'b0;
  logic [7:0]        data  = 8'h00;
  logic [ADDR_W-1:0] o_waddr;
  logic [PIX_W-1:0]  o_wdata;
  logic              o_wr;
  logic              o_frame_done;
  logic              o_armed;
`ifdef CAM_CAPTURE_STATUS_EN
  logic              o_frame_err;
  logic [LINE_W-1:0] o_line_count;
`endif

  cam_capture #(.START_FRAMES(SF), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_p_clk      (clk),
    .i_rstn       (rstn),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_data       (data),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_wr         (o_wr),
    .o_frame_done (o_frame_done),
    .o_armed      (o_armed)
`ifdef CAM_CAPTURE_STATUS_EN
    ,
    .o_frame_err  (o_frame_err),
    .o_line_count (o_line_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int addr;
    int pix;
    int at;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  // Reference model state, advanced once per driven byte.
  int   m_rises, m_addr, m_wr_total, m_done_total;
  bit   m_wait, m_armed, m_phase, m_prev_vs, m_prev_href;
  logic [3:0] m_r;
  int   m_wrcnt, m_lines, m_line_cnt;
  bit   m_ovf, m_err;

  task automatic model_reset();
    m_rises = 0; m_addr = 0; m_wait = 0; m_armed = 0; m_phase = 0;
    m_prev_vs = 0; m_prev_href = 0; m_r = '0;
    m_wrcnt = 0; m_lines = 0; m_line_cnt = 0; m_ovf = 0; m_err = 0;
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    int k;
    bit rise, fall;
    logic [11:0] p;
    @(negedge clk);
    vsync = vs; href = hr; data = d;
    k = cyc + 1;
    rise = vs && !m_prev_vs;
    fall = !vs && m_prev_vs;
    if (m_prev_href && !hr) m_lines++;
    if (rise) begin
      if (m_armed) begin
        done_q.push_back(k + 2);
        m_done_total++;
        m_line_cnt = m_lines;
        if (m_wrcnt != int'(FP) || m_ovf) m_err = 1;
        m_addr = 0;
      end else if (!m_wait) begin
        m_rises++;
        if (m_rises >= int'(SF)) m_wait = 1;
      end
      m_lines = 0;
    end
    if (fall && m_wait) begin
      m_wait = 0; m_armed = 1; m_addr = 0;
    end
    if (rise || fall) begin
      m_wrcnt = 0; m_ovf = 0;
    end
    if (hr && !rise && !fall) begin
      if (!m_phase) begin
        m_r = d[3:0];
        m_phase = 1;
      end else begin
        m_phase = 0;
        if (m_armed) begin
          p = {m_r, d};
          if (m_addr < int'(FP)) begin
            wr_q.push_back('{addr: m_addr, pix: int'(p), at: k + 2});
            m_addr++; m_wrcnt++; m_wr_total++;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end else begin
      m_phase = 0;
    end
    m_prev_vs = vs;
    m_prev_href = hr;
  endtask

  int  n_wr_seen = 0;
  int  n_done_seen = 0;
  wr_t e;

  always @(negedge clk) begin
    if (wr_q.size() > 0 && wr_q[0].at < cyc) begin
      e = wr_q.pop_front();
      check("missing_wr", 32'(0), 32'(1));
    end
    if (done_q.size() > 0 && done_q[0] < cyc) begin
      void'(done_q.pop_front());
      check("missing_done", 32'(0), 32'(1));
    end
    if (o_wr) begin
      n_wr_seen++;
      if (wr_q.size() == 0) check("unexpected_wr", 32'(1), 32'(0));
      else begin
        e = wr_q.pop_front();
        check("waddr", 32'(o_waddr), 32'(e.addr));
        check("wdata", 32'(o_wdata), 32'(e.pix));
        check("wr_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (o_frame_done) begin
      n_done_seen++;
      check("done_waddr", 32'(o_waddr), 32'(0));
      if (done_q.size() == 0) check("unexpected_done", 32'(1), 32'(0));
      else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  task automatic line_const(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? b0 : b1);
    idle(2);
  endtask

  task automatic line_rand(input int nbytes);
    for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 8'($urandom));
    idle(1 + int'($urandom_range(0, 2)));
  endtask

  task automatic frame_rand(input int nlines, input bit odd);
    for (int l = 0; l < nlines; l++)
      line_rand(2 * int'(H) + ((odd && $urandom_range(0, 1) == 1) ? 1 : 0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    @(negedge clk);
    check("rst_armed", 32'(o_armed), 32'(0));
    check("rst_waddr", 32'(o_waddr), 32'(0));
    check("rst_wr", 32'(o_wr), 32'(0));
    check("rst_done", 32'(o_frame_done), 32'(0));
    check("rst_wdata", 32'(o_wdata), 32'(0));
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic checkpoint(input string tag);
    idle(4);
    check({tag, "_wr_pending"}, 32'(wr_q.size()), 32'(0));
    check({tag, "_done_pending"}, 32'(done_q.size()), 32'(0));
    check({tag, "_wr_total"}, 32'(n_wr_seen), 32'(m_wr_total));
    check({tag, "_done_total"}, 32'(n_done_seen), 32'(m_done_total));
    check({tag, "_armed"}, 32'(o_armed), 32'(m_armed));
`ifdef CAM_CAPTURE_STATUS_EN
    check({tag, "_frame_err"}, 32'(o_frame_err), 32'(m_err));
    check({tag, "_line_count"}, 32'(o_line_count), 32'(m_line_cnt));
`endif
  endtask

  initial begin
    m_wr_total = 0;
    m_done_total = 0;
    model_reset();
    pulse_reset();

    // Two settling frames, then one captured frame of constant 0xABC.
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < int'(V); l++) line_const(2 * int'(H), 8'h0A, 8'hBC);
      vs_pulse();
    end
    checkpoint("const3");
    check("const3_writes", 32'(n_wr_seen), 32'(FP));
    check("const3_done", 32'(n_done_seen), 32'(1));

    // Directed pair of pixels at the head of a frame.
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h23);
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h56);
    idle(4);
    check("pair_writes", 32'(n_wr_seen), 32'(FP + 2));
    vs_pulse();

    // Odd trailing byte followed by a normal line.
    line_rand(2 * int'(H) + 1);
    line_rand(2 * int'(H));
    vs_pulse();
    checkpoint("odd_line");

    // Overlong frame saturates, next frame restarts at 0.
    frame_rand(int'(V) + 1, 1'b0);
    vs_pulse();
    frame_rand(int'(V), 1'b0);
    vs_pulse();
    checkpoint("overflow");

    for (int f = 0; f < 6; f++) begin
      frame_rand(int'(V) - 1 + int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      vs_pulse();
    end
    checkpoint("random");

    // VSYNC rises on the same byte that completes a pixel.
    for (int i = 0; i < 2 * int'(H) - 1; i++) drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'h77);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    idle(3);
    checkpoint("coincident");

    // Reset in the middle of a captured frame re-runs the settling frames.
    line_rand(2 * int'(H));
    line_rand(2 * int'(H));
    idle(3);
    check("pre_reset_armed", 32'(o_armed), 32'(1));
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      frame_rand(int'(V), 1'b0);
      vs_pulse();
    end
    checkpoint("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
